// File: rtl/zamek_ctrl.sv
// Code-lock sequencer: steers keypad digits into a register bank via one-hot
// clock enables, checks the bank against the stored code on enter, and drives
// unlock / failure handling with a try counter and alarm lockout.
module zamek_ctrl #(
  parameter int unsigned               DIGITS      = 4,
  parameter int unsigned               WIDTH       = 4,
  parameter logic [DIGITS*WIDTH-1:0]   CODE        = 16'h1234,
  parameter int unsigned               MAX_TRIES   = 3,
  parameter int unsigned               OPEN_CYC    = 500,
  parameter int unsigned               LOCKOUT_CYC = 1000
) (
  input  logic                          clk_i,
  input  logic                          clr_ni,
  input  logic                          key_valid_i,
  input  logic [WIDTH-1:0]              key_data_i,
  input  logic                          key_enter_i,
  input  logic                          key_cancel_i,
  input  logic [DIGITS*WIDTH-1:0]       entry_q_i,
  output logic [DIGITS-1:0]             reg_ce_o,
  output logic                          reg_clr_o,
  output logic [WIDTH-1:0]              reg_data_o,
  output logic [$clog2(DIGITS+1)-1:0]   digit_cnt_o,
  output logic                          unlock_o,
  output logic                          alarm_o,
  output logic                          busy_o
);

  localparam int unsigned CntW   = $clog2(DIGITS + 1);
  localparam int unsigned TryW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned TmrMax = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int unsigned TmrW   = $clog2(TmrMax + 1);

  typedef enum logic [2:0] {
    StIdle, StEntry, StWait, StCheck, StOpen, StFail, StLockout
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [TryW-1:0]   tries_q, tries_d;
  logic [TryW-1:0]   tries_inc;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [DIGITS-1:0] ce_q, ce_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              clr_q, clr_d;
  logic              unlock_q, unlock_d;
  logic              alarm_q, alarm_d;
  logic              busy_q, busy_d;

  // Saturating increment so tries never exceeds MAX_TRIES.
  assign tries_inc = (tries_q < TryW'(MAX_TRIES)) ? tries_q + TryW'(1) : tries_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    tries_d  = tries_q;
    timer_d  = timer_q;
    ce_d     = '0;
    data_d   = '0;
    clr_d    = 1'b0;
    unlock_d = 1'b0;
    alarm_d  = 1'b0;

    unique case (state_q)
      StIdle, StEntry: begin
        if (key_cancel_i) begin
          state_d = StIdle;
          clr_d   = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (key_enter_i) begin
          state_d = StWait;
        end else if (key_valid_i) begin
          state_d = StEntry;
          if (cnt_q < CntW'(DIGITS)) begin
            ce_d   = DIGITS'(1) << cnt_q;
            data_d = key_data_i;
            cnt_d  = cnt_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end
      // One spare cycle so the final digit's register load is visible.
      StWait: state_d = StCheck;
      StCheck: begin
        if ((cnt_q == CntW'(DIGITS)) && !ovf_q && (entry_q_i == CODE)) begin
          state_d  = StOpen;
          timer_d  = TmrW'(OPEN_CYC - 1);
          unlock_d = 1'b1;
          tries_d  = '0;
        end else begin
          state_d = StFail;
        end
      end
      StOpen: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          clr_d   = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          timer_d  = timer_q - TmrW'(1);
          unlock_d = 1'b1;
        end
      end
      StFail: begin
        tries_d = tries_inc;
        if (tries_inc == TryW'(MAX_TRIES)) begin
          state_d = StLockout;
          timer_d = TmrW'(LOCKOUT_CYC - 1);
          alarm_d = 1'b1;
        end else begin
          state_d = StIdle;
          clr_d   = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StLockout: begin
        if (timer_q == '0) begin
          state_d = StIdle;
          tries_d = '0;
          clr_d   = 1'b1;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else begin
          timer_d = timer_q - TmrW'(1);
          alarm_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        clr_d   = 1'b1;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase

    busy_d = !((state_d == StIdle) || (state_d == StEntry));
  end

  // State and output registers; reset holds the bank clear asserted.
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      tries_q  <= '0;
      timer_q  <= '0;
      ce_q     <= '0;
      data_q   <= '0;
      clr_q    <= 1'b1;
      unlock_q <= 1'b0;
      alarm_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      tries_q  <= tries_d;
      timer_q  <= timer_d;
      ce_q     <= ce_d;
      data_q   <= data_d;
      clr_q    <= clr_d;
      unlock_q <= unlock_d;
      alarm_q  <= alarm_d;
      busy_q   <= busy_d;
    end
  end

  assign reg_ce_o    = ce_q;
  assign reg_clr_o   = clr_q;
  assign reg_data_o  = data_q;
  assign digit_cnt_o = cnt_q;
  assign unlock_o    = unlock_q;
  assign alarm_o     = alarm_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_zamek_ctrl.sv
// Bench for zamek_ctrl: models the digit register bank, applies a vector
// table, hand-written corner sequences and random attempts scored against a
// transaction-level model of the lock.
module tb_zamek_ctrl;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned WIDTH       = 4;
  localparam logic [15:0] CODE        = 16'h1234;
  localparam int unsigned MAX_TRIES   = 3;
  localparam int unsigned OPEN_CYC    = 8;
  localparam int unsigned LOCKOUT_CYC = 16;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_data = '0;
  logic        key_enter = 1'b0;
  logic        key_cancel = 1'b0;
  logic [15:0] entry_q;
  logic [3:0]  reg_ce;
  logic        reg_clr;
  logic [3:0]  reg_data;
  logic [2:0]  digit_cnt;
  logic        unlock, alarm, busy;

  always #5 clk = ~clk;

  zamek_ctrl #(
    .DIGITS      (DIGITS),
    .WIDTH       (WIDTH),
    .CODE        (CODE),
    .MAX_TRIES   (MAX_TRIES),
    .OPEN_CYC    (OPEN_CYC),
    .LOCKOUT_CYC (LOCKOUT_CYC)
  ) dut (
    .clk_i        (clk),
    .clr_ni       (clr_n),
    .key_valid_i  (key_valid),
    .key_data_i   (key_data),
    .key_enter_i  (key_enter),
    .key_cancel_i (key_cancel),
    .entry_q_i    (entry_q),
    .reg_ce_o     (reg_ce),
    .reg_clr_o    (reg_clr),
    .reg_data_o   (reg_data),
    .digit_cnt_o  (digit_cnt),
    .unlock_o     (unlock),
    .alarm_o      (alarm),
    .busy_o       (busy)
  );

  // Register bank: DIGITS clear/enable registers, clear has priority.
  logic [3:0] bank [DIGITS];
  always @(posedge clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (reg_clr) bank[i] <= '0;
      else if (reg_ce[i]) bank[i] <= reg_data;
    end
  end
  always_comb begin
    entry_q = '0;
    for (int i = 0; i < DIGITS; i++) entry_q[(DIGITS-1-i)*4 +: 4] = bank[i];
  end

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] code_v;

  typedef struct {
    logic       v;
    logic [3:0] d;
    logic       c;
    logic       e;
    logic [3:0] ce;
    logic [3:0] data;
    logic [2:0] cnt;
    logic       clr;
    logic       busy;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(int v, int d, int c, int e, int ce, int data, int cnt,
                              int clr, int bsy);
    vec_t r;
    r.v = v[0]; r.d = d[3:0]; r.c = c[0]; r.e = e[0];
    r.ce = ce[3:0]; r.data = data[3:0]; r.cnt = cnt[2:0]; r.clr = clr[0]; r.busy = bsy[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of key inputs; returns just after the sampling edge.
  task automatic key(input int v, input int d, input int c, input int e);
    key_valid  = (v != 0);
    key_data   = d[3:0];
    key_cancel = (c != 0);
    key_enter  = (e != 0);
    tick();
    key_valid  = 1'b0;
    key_data   = '0;
    key_cancel = 1'b0;
    key_enter  = 1'b0;
  endtask

  // Type n digits (MS nibble first), one digit every 3 cycles, from an empty entry.
  task automatic type_digits(input string tag, input logic [31:0] seq, input int n);
    for (int k = 0; k < n; k++) begin
      logic [3:0] dg;
      dg = seq[(n-1-k)*4 +: 4];
      key(1, int'(dg), 0, 0);
      chk({tag, ".ce"}, 32'(reg_ce), (k < DIGITS) ? (1 << k) : 0);
      chk({tag, ".data"}, 32'(reg_data), (k < DIGITS) ? int'(dg) : 0);
      chk({tag, ".cnt"}, 32'(digit_cnt), (k < DIGITS) ? k + 1 : DIGITS);
      tick();
      tick();
    end
  endtask

  // Press enter and follow the attempt through to IDLE.
  task automatic enter_expect(input string tag, input bit pass, input bit lock);
    int n;
    key(0, 0, 0, 1);
    chk({tag, ".busy_wait"}, 32'(busy), 1);
    chk({tag, ".unlock_wait"}, 32'(unlock), 0);
    tick();
    chk({tag, ".unlock_check"}, 32'(unlock), 0);
    tick();
    chk({tag, ".unlock"}, 32'(unlock), pass ? 1 : 0);
    if (pass) begin
      n = 0;
      while (unlock && n < 100) begin
        n++;
        tick();
      end
      chk({tag, ".open_len"}, 32'(n), OPEN_CYC);
      chk({tag, ".open_clr"}, 32'(reg_clr), 1);
      chk({tag, ".open_cnt"}, 32'(digit_cnt), 0);
    end else begin
      tick();
      chk({tag, ".alarm"}, 32'(alarm), lock ? 1 : 0);
      if (lock) begin
        n = 0;
        while (alarm && n < 100) begin
          n++;
          key(1, 1, 0, (n == 3) ? 1 : 0);
          chk({tag, ".lock_ce"}, 32'(reg_ce), 0);
          chk({tag, ".lock_unlock"}, 32'(unlock), 0);
        end
        chk({tag, ".lock_len"}, 32'(n), LOCKOUT_CYC);
      end
      chk({tag, ".fail_clr"}, 32'(reg_clr), 1);
      chk({tag, ".fail_cnt"}, 32'(digit_cnt), 0);
    end
    n = 0;
    while (busy && n < 200) begin
      n++;
      tick();
    end
    chk({tag, ".idle"}, 32'(busy), 0);
    tick();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    code_v = CODE;

    // Reset values, reg_clr held through reset, drops at first edge after release.
    clr_n = 1'b0;
    repeat (3) tick();
    chk("rst.ce", 32'(reg_ce), 0);
    chk("rst.clr", 32'(reg_clr), 1);
    chk("rst.data", 32'(reg_data), 0);
    chk("rst.cnt", 32'(digit_cnt), 0);
    chk("rst.unlock", 32'(unlock), 0);
    chk("rst.alarm", 32'(alarm), 0);
    chk("rst.busy", 32'(busy), 0);
    clr_n = 1'b1;
    #1;
    chk("rel.clr_held", 32'(reg_clr), 1);
    tick();
    chk("rel.clr_drop", 32'(reg_clr), 0);

    // Vector table: v, d, cancel, enter | ce, data, cnt, clr, busy.
    tbl[0]  = mk(1, 1, 0, 0, 4'b0001, 1, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 4'b0000, 0, 1, 0, 0);
    tbl[2]  = mk(1, 2, 0, 0, 4'b0010, 2, 2, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 4'b0000, 0, 2, 0, 0);
    tbl[4]  = mk(1, 3, 1, 0, 4'b0000, 0, 0, 1, 0);
    tbl[5]  = mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 4'b0001, 1, 1, 0, 0);
    tbl[7]  = mk(1, 2, 0, 0, 4'b0010, 2, 2, 0, 0);
    tbl[8]  = mk(1, 3, 0, 0, 4'b0100, 3, 3, 0, 0);
    tbl[9]  = mk(1, 4, 0, 0, 4'b1000, 4, 4, 0, 0);
    tbl[10] = mk(1, 5, 0, 0, 4'b0000, 0, 4, 0, 0);
    tbl[11] = mk(0, 0, 1, 0, 4'b0000, 0, 0, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      key(int'(tbl[i].v), int'(tbl[i].d), int'(tbl[i].c), int'(tbl[i].e));
      chk($sformatf("tbl%0d.ce", i), 32'(reg_ce), int'(tbl[i].ce));
      chk($sformatf("tbl%0d.data", i), 32'(reg_data), int'(tbl[i].data));
      chk($sformatf("tbl%0d.cnt", i), 32'(digit_cnt), int'(tbl[i].cnt));
      chk($sformatf("tbl%0d.clr", i), 32'(reg_clr), int'(tbl[i].clr));
      chk($sformatf("tbl%0d.busy", i), 32'(busy), int'(tbl[i].busy));
    end
    tick();

    // Correct code opens the door.
    type_digits("okA", 32'h1234, 4);
    chk("okA.bank", 32'(entry_q), 32'h1234);
    enter_expect("okA", 1'b1, 1'b0);

    // Two wrong codes, a cancel, then an overflow entry reaches lockout.
    type_digits("bad1", 32'h123, 3);
    enter_expect("bad1", 1'b0, 1'b0);
    type_digits("bad2", 32'h1235, 4);
    enter_expect("bad2", 1'b0, 1'b0);
    type_digits("cxl", 32'h12, 2);
    key(1, 3, 1, 0);
    chk("cxl.ce", 32'(reg_ce), 0);
    chk("cxl.clr", 32'(reg_clr), 1);
    chk("cxl.cnt", 32'(digit_cnt), 0);
    tick();
    tick();
    type_digits("ovf", 32'h12344, 5);
    enter_expect("ovf", 1'b0, 1'b1);
    type_digits("okB", 32'h1234, 4);
    enter_expect("okB", 1'b1, 1'b0);

    // Reset dropped while the door is open.
    type_digits("rstO", 32'h1234, 4);
    key(0, 0, 0, 1);
    tick();
    tick();
    chk("rstO.open", 32'(unlock), 1);
    tick();
    #2;
    clr_n = 1'b0;
    #1;
    chk("rstO.unlock", 32'(unlock), 0);
    chk("rstO.clr", 32'(reg_clr), 1);
    chk("rstO.busy", 32'(busy), 0);
    chk("rstO.alarm", 32'(alarm), 0);
    tick();
    tick();
    clr_n = 1'b1;
    tick();
    chk("rstO.rel_clr", 32'(reg_clr), 0);
    chk("rstO.rel_unlock", 32'(unlock), 0);
    chk("rstO.rel_busy", 32'(busy), 0);
    tick();

    // Random attempts against a transaction-level model of the lock.
    begin
      int tries_m;
      tries_m = 0;
      for (int a = 0; a < 40; a++) begin
        logic [3:0] typed[$];
        int nd;
        bit pass, lock;
        typed.delete();
        nd = int'($urandom_range(2, 5));
        for (int k = 0; k < nd; k++) begin
          logic [3:0] dg;
          int sz;
          if ($urandom_range(0, 11) == 0) begin
            key(0, 0, 1, 0);
            typed.delete();
            chk("rnd.cxl_cnt", 32'(digit_cnt), 0);
            chk("rnd.cxl_clr", 32'(reg_clr), 1);
          end
          sz = typed.size();
          if ($urandom_range(0, 3) != 0 && sz < DIGITS) dg = code_v[(DIGITS-1-sz)*4 +: 4];
          else dg = 4'($urandom_range(0, 15));
          key(1, int'(dg), 0, 0);
          chk("rnd.ce", 32'(reg_ce), (sz < DIGITS) ? (1 << sz) : 0);
          chk("rnd.cnt", 32'(digit_cnt), (sz < DIGITS) ? sz + 1 : DIGITS);
          typed.push_back(dg);
          repeat ($urandom_range(0, 2)) tick();
        end
        pass = (typed.size() == DIGITS);
        for (int k = 0; k < typed.size() && k < DIGITS; k++)
          if (typed[k] != code_v[(DIGITS-1-k)*4 +: 4]) pass = 1'b0;
        lock = 1'b0;
        if (pass) tries_m = 0;
        else begin
          tries_m++;
          if (tries_m == MAX_TRIES) begin
            lock = 1'b1;
            tries_m = 0;
          end
        end
        enter_expect($sformatf("rnd%0d", a), pass, lock);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
